pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_pc.sv | 26 ++
 rtl/pc_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } pc_seq_state_t;

  // Instructions are word aligned; any set low bit makes a redirect illegal.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_pc.sv
// ProgramCounter register: loads RESET_VECTOR on reset, otherwise takes pc_next.
module pc_sequencer_pc
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] pc_q;

  // PC storage with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: boot/fetch/wait/halt control, next-PC selection, trap and mret.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic            fetch_valid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] epc,
  output logic            halted
);

  pc_seq_state_t  state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            halted_q, halted_d;
  logic            req_s;
  logic            fire_s;

  pc_sequencer_pc #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .pc_next(pc_d),
    .pc_out (pc_q)
  );

  // Fetch request is suppressed combinationally while reset is held
  always_comb begin
    req_s  = ((state_q == ST_FETCH) || (state_q == ST_WAIT)) && !reset;
    fire_s = req_s && imem_ready;
  end

  // Next-state, next-PC and epc selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH, ST_WAIT: begin
        if (imem_ready) begin
          state_d = ST_FETCH;
          if (trap || (branch_taken && !mret && is_misaligned(branch_target))) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
          end else if (mret) begin
            pc_d = epc_q;
          end else if (branch_taken) begin
            pc_d = branch_target;
          end else if (halt) begin
            pc_d    = pc_q + PC_INC;
            state_d = ST_HALTED;
          end else if (stall) begin
            pc_d = pc_q;
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end else begin
          // A trap is taken even while the fetch is still outstanding
          state_d = ST_WAIT;
          if (trap) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  // FSM state, epc and halted flag with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      epc_q    <= {XLEN{1'b0}};
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req    = req_s;
  assign fetch_valid = fire_s;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign epc         = epc_q;
  assign halted      = halted_q;

endmodule
